axi4_mem_master: RTL

- AXI4 initiator that drives the AXI4 memory slave: converts simple single-burst read/write commands from a client into AW/W/B or AR/R channel traffic.
- Serves as the bus-side driver for the memory subsystem and as a reusable active agent in the memory test top.
- One transaction outstanding at a time; INCR bursts only; full-width 32-bit beats.

---
 rtl/axi4_mem_pkg.sv | 30 +++
 rtl/axi4_mem_burst_cnt.sv | 30 +++
 rtl/axi4_mem_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_pkg.sv
// Shared constants, state encoding and helpers for the AXI4 memory initiator.
package axi4_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam int unsigned MEM_BYTES = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StChk,
        StAw,
        StW,
        StB,
        StAr,
        StR,
        StDone
    } state_e;

    // Worst-of two responses; the AXI encodings are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_mem_burst_cnt.sv
// Loadable beat counter with a last-beat flag, shared by the write and read data paths.
module axi4_mem_burst_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       last
);

    // Nine bits so a 256-beat burst can step past beat 255 without wrapping.
    logic [8:0] count_q;
    logic [7:0] len_q;

    // Clear and capture the burst length on load, count accepted beats otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            len_q   <= '0;
        end else if (load) begin
            count_q <= '0;
            len_q   <= len;
        end else if (inc) begin
            count_q <= count_q + 9'd1;
        end
    end

    assign last = (count_q == {1'b0, len_q});

endmodule

// File: rtl/axi4_mem_master.sv
// Single-outstanding AXI4 initiator: turns one client burst command into AW/W/B or AR/R traffic.
module axi4_mem_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_BYTES  = 4096
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // Client command
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    // Client write-data stream
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    // Client read-data stream
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,
    // Completion
    output logic                      done,
    output logic [1:0]                done_resp,
    // AW channel
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [7:0]                AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    // W channel
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,
    // B channel
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    // AR channel
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    // R channel
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY
);

    import axi4_mem_pkg::*;

    localparam int unsigned OFF_W = $clog2(MEM_BYTES);

    state_e                state_q, state_d;
    logic                  cmd_ready_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [1:0]            acc_q, acc_d;
    logic                  rlast_err_q, rlast_err_d;
    logic [1:0]            done_resp_q, done_resp_d;

    logic                  cnt_load, cnt_inc, cnt_last;
    logic                  cmd_fire, w_fire, r_fire;
    logic [OFF_W+1:0]      span_end;
    logic                  reject;

    // cmd_ready_q is only ever high while sitting in idle, so it alone qualifies acceptance.
    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign w_fire   = (state_q == StW) && wr_valid && WREADY;
    assign r_fire   = (state_q == StR) && RVALID && rd_ready;

    // End of the burst within the aperture; anything past MEM_BYTES crosses the 4KB boundary.
    assign span_end = (OFF_W+2)'(addr_q[OFF_W-1:0]) + (OFF_W+2)'({len_q, 2'b00})
                    + (OFF_W+2)'(4);
    assign reject   = (addr_q[1:0] != 2'b00) || (span_end > (OFF_W+2)'(MEM_BYTES));

    axi4_mem_burst_cnt u_burst_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .len   (len_q),
        .last  (cnt_last)
    );

    // Next-state, beat counting and response accumulation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rlast_err_d = rlast_err_q;
        done_resp_d = done_resp_q;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = StChk;
                end
            end
            StChk: begin
                acc_d       = RESP_OKAY;
                rlast_err_d = 1'b0;
                cnt_load    = 1'b1;
                if (reject) begin
                    done_resp_d = RESP_SLVERR;
                    state_d     = StDone;
                end else begin
                    state_d = write_q ? StAw : StAr;
                end
            end
            StAw: begin
                if (AWREADY) begin
                    state_d = StW;
                end
            end
            StW: begin
                if (w_fire) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = StB;
                    end
                end
            end
            StB: begin
                if (BVALID) begin
                    done_resp_d = BRESP;
                    state_d     = StDone;
                end
            end
            StAr: begin
                if (ARREADY) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (r_fire) begin
                    cnt_inc     = 1'b1;
                    acc_d       = resp_max(acc_q, RRESP);
                    // A slave RLAST out of step with our own count poisons the whole burst.
                    rlast_err_d = rlast_err_q || (RLAST != cnt_last);
                    if (cnt_last) begin
                        done_resp_d = rlast_err_d ? RESP_SLVERR : acc_d;
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, handshake and response registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            acc_q       <= RESP_OKAY;
            rlast_err_q <= 1'b0;
            done_resp_q <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == StIdle);
            acc_q       <= acc_d;
            rlast_err_q <= rlast_err_d;
            done_resp_q <= done_resp_d;
        end
    end

    // Command capture on acceptance; held stable for the whole transaction.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else if (cmd_fire) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = (state_q == StDone);
    assign done_resp = done_resp_q;

    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = SIZE_4B;
    assign AWBURST = BURST_INCR;
    assign AWVALID = (state_q == StAw);

    // Write data passes straight through; only the beat count is registered.
    assign WDATA    = (state_q == StW) ? wr_data : '0;
    assign WSTRB    = '1;
    assign WLAST    = (state_q == StW) && cnt_last;
    assign WVALID   = (state_q == StW) && wr_valid;
    assign wr_ready = (state_q == StW) && WREADY;

    assign BREADY = (state_q == StB);

    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = SIZE_4B;
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state_q == StAr);

    assign RREADY   = (state_q == StR) && rd_ready;
    assign rd_valid = (state_q == StR) && RVALID;
    assign rd_data  = (state_q == StR) ? RDATA : '0;
    assign rd_last  = (state_q == StR) && cnt_last;

endmodule
